// File: rtl/cnn_acc_requant_23s_14s.sv
// ---------------------------------------------------------------------------
// cnn_acc_requant_23s_14s
//
// Accumulates one kernel window of signed multiplier products onto a bias.
// The sum is then rounded (half up), arithmetically shifted and saturated
// back to the signed activation format, with optional ReLU. The result is
// presented on a valid/ready interface.
//
// Ports:
//   ap_clk    in   clock, rising edge
//   ap_rst_n  in   asynchronous active-low reset
//   s_valid   in   product valid
//   s_ready   out  block accepts a product (ACC state)
//   s_prod    in   signed product, PROD_WIDTH bits
//   bias      in   signed bias, sampled with the first product of a window
//   relu_en   in   clamp negative results to zero, sampled in RND
//   m_valid   out  result valid (OUT state)
//   m_ready   in   downstream accepts the result
//   m_data    out  signed requantized result, OUT_WIDTH bits
//   sat_o     out  sticky flag, set when any result saturated
// ---------------------------------------------------------------------------
module cnn_acc_requant_23s_14s #(
  parameter int PROD_WIDTH = 23,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 14,
  parameter int NUM_TERMS  = 9,
  parameter int SHIFT      = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [PROD_WIDTH-1:0] s_prod,
  input  logic signed [OUT_WIDTH-1:0]  bias,
  input  logic                         relu_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [OUT_WIDTH-1:0]  m_data,
  output logic                         sat_o
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_TERMS - 1);

  // Rounding constant 2^(SHIFT-1) and the output range limits, all at
  // accumulator width so comparisons happen before any truncation.
  localparam logic signed [ACC_WIDTH-1:0] C_HALF =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] C_OMAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] C_OMIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RND = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t                        r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [OUT_WIDTH-1:0]   r_mdata;
  logic                          r_sat;

  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_sh;
  logic signed [ACC_WIDTH-1:0]   w_rnd;
  logic signed [OUT_WIDTH-1:0]   w_satv;
  logic signed [OUT_WIDTH-1:0]   w_res;
  logic                          w_clip;
  logic                          w_hs;

  // Round half up, then drop SHIFT fractional bits.
  function automatic logic signed [ACC_WIDTH-1:0] f_round(
    input logic signed [ACC_WIDTH-1:0] a
  );
    return (a + C_HALF) >>> SHIFT;
  endfunction

  function automatic logic f_clips(input logic signed [ACC_WIDTH-1:0] a);
    return (a > C_OMAX) || (a < C_OMIN);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] f_sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    if (a > C_OMAX) begin
      return C_OMAX[OUT_WIDTH-1:0];
    end else if (a < C_OMIN) begin
      return C_OMIN[OUT_WIDTH-1:0];
    end else begin
      return a[OUT_WIDTH-1:0];
    end
  endfunction

  // Handshake flags come straight from the registered state.
  assign s_ready = (r_state == ST_ACC);
  assign m_valid = (r_state == ST_OUT);
  assign m_data  = r_mdata;
  assign sat_o   = r_sat;

  assign w_hs       = s_valid && (r_state == ST_ACC);
  assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){s_prod[PROD_WIDTH-1]}}, s_prod};
  assign w_bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias};
  assign w_bias_sh  = w_bias_ext <<< SHIFT;

  // Requantization path; ReLU follows saturation so a ReLU clamp alone
  // never contributes to the sticky saturation flag.
  assign w_rnd  = f_round(r_acc);
  assign w_clip = f_clips(w_rnd);
  assign w_satv = f_sat(w_rnd);
  assign w_res  = (relu_en && w_satv[OUT_WIDTH-1]) ? '0 : w_satv;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mdata <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        // Accumulate one window; first product seeds the bias.
        ST_ACC: begin
          if (w_hs) begin
            if (r_cnt == '0) begin
              r_acc <= w_bias_sh + w_prod_ext;
            end else begin
              r_acc <= r_acc + w_prod_ext;
            end
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_RND;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        // Register the requantized result.
        ST_RND: begin
          r_mdata <= w_res;
          if (w_clip) begin
            r_sat <= 1'b1;
          end
          r_state <= ST_OUT;
        end
        // Hold the result until downstream takes it.
        ST_OUT: begin
          if (m_ready) begin
            r_state <= ST_ACC;
          end
        end
        default: begin
          r_state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_acc_requant_23s_14s.sv
module tb_cnn_acc_requant_23s_14s;

  localparam int PW = 23;
  localparam int OW = 14;
  localparam int NT = 9;
  localparam int SH = 8;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [PW-1:0] s_prod;
  logic signed [OW-1:0] bias;
  logic                 relu_en;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data;
  logic                 sat_o;

  cnn_acc_requant_23s_14s #(
    .PROD_WIDTH(PW), .ACC_WIDTH(32), .OUT_WIDTH(OW), .NUM_TERMS(NT), .SHIFT(SH)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_prod  (s_prod),
    .bias    (bias),
    .relu_en (relu_en),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .sat_o   (sat_o)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint data;
    longint sat;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_push   = 0;
  int     n_out    = 0;
  bit     sat_model = 1'b0;
  int     prods[NT];

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, floor division for the shift.
  task automatic push_expected(input int b, input bit relu);
    longint acc;
    longint num;
    longint r;
    bit     clip;
    exp_t   e;
    acc = longint'(b) * 256;
    for (int i = 0; i < NT; i++) acc += longint'(prods[i]);
    num = acc + 128;
    r = num / 256;
    if (num < 0 && (num % 256) != 0) r = r - 1;
    clip = (r > 8191) || (r < -8192);
    if (r > 8191) r = 8191;
    if (r < -8192) r = -8192;
    if (relu && r < 0) r = 0;
    sat_model = sat_model | clip;
    e.data = r;
    e.sat  = sat_model;
    q.push_back(e);
    n_push++;
  endtask

  always @(negedge ap_clk) begin : mon
    exp_t e;
    if (ap_rst_n && m_valid && m_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("m_data", m_data, e.data);
        chk("sat_o", sat_o, e.sat);
      end
    end
  end

  // Called and returns at 1ns after a rising edge.
  task automatic drive_prod(input int p, input int b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_prod  = PW'(p);
    bias    = OW'(b);
    while (!s_ready && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 100) chk("s_ready_timeout", s_ready, 1);
    @(posedge ap_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input bit level, input string tag);
    int n;
    n = 0;
    while (m_valid !== level && n < 50) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 50) chk(tag, m_valid, level);
  endtask

  task automatic fill(input int first, input int rest);
    prods[0] = first;
    for (int i = 1; i < NT; i++) prods[i] = rest;
  endtask

  // Later products carry a different bias value, which must be ignored.
  task automatic do_window(input int b, input bit relu, input bit gap, input bit wait_out);
    relu_en = relu;
    push_expected(b, relu);
    for (int i = 0; i < NT; i++) begin
      drive_prod(prods[i], (i == 0) ? b : b + 77);
      if (gap && (i % 2 == 0)) begin
        @(posedge ap_clk); #1;
      end
    end
    if (wait_out) begin
      wait_mvalid(1'b1, "wait_valid");
      wait_mvalid(1'b0, "wait_release");
    end
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    s_valid  = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_sat_o", sat_o, 0);
    @(posedge ap_clk); #1;
    ap_rst_n  = 1'b1;
    sat_model = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int b;
    ap_rst_n = 1'b0;
    s_valid  = 1'b0;
    s_prod   = '0;
    bias     = '0;
    relu_en  = 1'b0;
    m_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_sat_o", sat_o, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("reset_s_ready", s_ready, 1);

    // Basic window with latency checks
    fill(256, 256);
    do_window(0, 1'b0, 1'b0, 1'b0);
    chk("lat_rnd_m_valid", m_valid, 0);
    chk("lat_rnd_s_ready", s_ready, 0);
    @(posedge ap_clk); #1;
    chk("lat_out_m_valid", m_valid, 1);
    chk("basic_m_data", m_data, 9);
    @(posedge ap_clk); #1;
    chk("lat_done_m_valid", m_valid, 0);
    chk("lat_done_s_ready", s_ready, 1);

    // Rounding and bias
    fill(384, 0);   do_window(0, 1'b0, 1'b0, 1'b1);
    fill(-384, 0);  do_window(0, 1'b0, 1'b0, 1'b1);
    fill(0, 0);     do_window(-5, 1'b0, 1'b0, 1'b1);

    // Saturation
    fill(4194303, 4194303);   do_window(0, 1'b0, 1'b0, 1'b1);
    fill(-4194304, -4194304); do_window(0, 1'b0, 1'b0, 1'b1);
    chk("sat_sticky", sat_o, 1);

    // ReLU after reset
    pulse_reset();
    fill(-384, 0); do_window(0, 1'b1, 1'b0, 1'b1);
    fill(384, 0);  do_window(0, 1'b1, 1'b0, 1'b1);
    chk("relu_no_sat", sat_o, 0);

    // Back-pressure with ignored product pulses
    m_ready = 1'b0;
    fill(256, 256);
    do_window(0, 1'b0, 1'b0, 1'b0);
    wait_mvalid(1'b1, "bp_wait_valid");
    for (int k = 0; k < 5; k++) begin
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_data", m_data, 9);
      s_valid = 1'b1;
      s_prod  = PW'(12345);
      @(posedge ap_clk); #1;
      s_valid = 1'b0;
    end
    m_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("bp_release_m_valid", m_valid, 0);
    chk("bp_release_s_ready", s_ready, 1);
    fill(256, 256); do_window(3, 1'b0, 1'b0, 1'b1);

    // Handshake gaps
    fill(256, 256); do_window(0, 1'b0, 1'b1, 1'b1);

    // Random windows
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < NT; i++)
        prods[i] = int'($urandom_range(0, 32'h7FFFFF)) - 4194304;
      b = int'($urandom_range(0, 16383)) - 8192;
      do_window(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset mid-window
    fill(4194303, 4194303); do_window(0, 1'b0, 1'b0, 1'b1);
    relu_en = 1'b0;
    for (int i = 0; i < 4; i++) drive_prod(1000, 11);
    pulse_reset();
    fill(256, 256); do_window(0, 1'b0, 1'b0, 1'b1);

    repeat (20) @(posedge ap_clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("out_count", n_out, n_push);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cnn_acc_requant_23s_14s.md
# cnn_acc_requant_23s_14s

Consumer end of the conv-layer multiplier datapath. Accepts the stream of signed 23-bit products from the 9s×14s multipliers and accumulates one kernel window of products onto a bias. It then rounds, shifts and saturates the sum back to the 14-bit signed activation format. The result goes out on a valid/ready interface to the feature-map writer, with optional ReLU.

## Interface
Parameters:
- PROD_WIDTH, 23, signed product width
- ACC_WIDTH, 32, signed accumulator width
- OUT_WIDTH, 14, signed output and bias width
- NUM_TERMS, 9, products per window (3×3 kernel), ≥1
- SHIFT, 8, fractional bits dropped at requantization, ≥1

Ports:
- ap_clk  in  1  clock; all logic on the rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  product valid
- s_ready  out  1  block accepts a product
- s_prod  in  PROD_WIDTH  signed product
- bias  in  OUT_WIDTH  signed bias, sampled with the first product of each window
- relu_en  in  1  clamp negative results to 0, sampled in RND
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- m_data  out  OUT_WIDTH  signed requantized result
- sat_o  out  1  sticky flag: some result has saturated

## Operation
- FSM has three states: ACC, RND, OUT. The reset state is ACC.
- **ACC**
  - s_ready=1.
  - A handshake is s_valid&s_ready.
  - On a handshake with cnt==0: acc ← sext(bias)<<SHIFT + sext(s_prod).
  - On a handshake with cnt>0: acc ← acc + sext(s_prod).
  - cnt increments on each handshake.
  - On the handshake with cnt==NUM_TERMS-1: cnt←0 and the FSM goes to RND.
- **RND**
  - s_ready=0.
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (round half up).
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-8192, 8191] at the defaults.
  - If relu_en=1 and r<0, the result is 0. ReLU is applied after saturation. A clamp by ReLU alone does not set sat_o.
  - m_data is registered with the result.
  - sat_o←1 if saturation clipped the value.
  - The FSM goes to OUT.
- **OUT**
  - m_valid=1 and s_ready=0.
  - m_data is held stable until m_ready=1.
  - On m_valid&m_ready the FSM goes to ACC.
- Arithmetic
  - All operations are signed two's complement at ACC_WIDTH.
  - The defaults cannot overflow: 9·2^22 + 2^21 < 2^31.
  - Accumulator overflow for other parameter sets is out of scope.
  - acc wraps; no check is made.
- s_prod is ignored whenever s_ready=0.
- bias is only sampled on the first handshake of a window.
- Reset values
  - FSM=ACC, cnt=0, acc=0
  - m_valid=0, m_data=0, sat_o=0
  - s_ready=1 after reset is released
- Reset asserted mid-window or mid-OUT discards the partial window and any pending result. No output is produced for it.

## Timing
- s_ready and m_valid are decoded from registered state only. There is no combinational path from s_valid or m_ready to any output.
- With the last product accepted at edge t:
  - RND during cycle t..t+1
  - m_valid=1 from edge t+1 onward, one cycle after RND
  - Result latency: 2 cycles from the last handshake to m_valid.
- Minimum window period is NUM_TERMS+2 cycles (11 at defaults) with s_valid and m_ready held high.
- Back-pressure: while m_ready=0 in OUT, the block stalls indefinitely. s_ready stays 0 and m_data/m_valid stay constant.
- Gaps in s_valid during ACC stall accumulation without losing cnt or acc.
- sat_o clears only on reset.

## Test plan
- Basic: bias=0, nine products of 256, relu_en=0, m_ready=1 → m_data=9, m_valid for 1 cycle at 2 cycles after the 9th handshake, sat_o=0.
- Rounding and bias:
  - Products {384, 0×8}, bias=0 → 2.
  - Products {-384, 0×8} → -1.
  - Products {0×9}, bias=-5 → -5.
- Saturation and ReLU:
  - Nine products of 4194303 → 8191, sat_o=1.
  - Nine products of -4194304 → -8192.
  - After reset, products {-384, 0×8} with relu_en=1 → 0, sat_o=0.
- Back-pressure: hold m_ready=0 for 5 cycles in OUT → m_data constant, s_ready=0, s_valid pulses ignored; m_ready=1 → one transfer, then ACC with cnt=0.
- Handshake gaps: s_valid toggled 1-0-1 across a window of 256s → result still 9; products offered while s_ready=0 are not counted.
- Reset mid-window: 4 products accepted, ap_rst_n low for 1 cycle, then a new full window of 256s → only one result, equal to 9; all outputs at reset values while ap_rst_n=0.
